// File: rtl/gps_acq_correlator.sv
// gps_acq_correlator: serial code-phase acquisition on a 1-bit received signal.
// Each dwell correlates CODE_LEN enabled samples against the local code and
// I/Q carrier replicas. When a dwell misses the threshold, the replica code is
// slipped by STEP samples. The search stops on detection or after a full sweep.
//
// Ports
//   clk_in, rst_in      clock, asynchronous active-high reset
//   ena_in              sample strobe
//   start_in            one-cycle pulse, starts a search from phase 0
//   abort_in            returns the block to IDLE (wins over start_in)
//   thr_in[15:0]        detection threshold on |I|+|Q|, latched on start
//   sample_in           received 1-bit sample
//   code_in             local replica chip
//   carr_i_in/_q_in     local carrier, in-phase / quadrature
//   code_ena_out        replica code enable (low while slipping), combinational
//   busy_out            search in progress
//   lock_out            threshold crossed
//   fail_out            sweep exhausted without detection
//   code_phase_out      total replica delay applied, in samples
//   peak_out            largest |I|+|Q| seen in this search
//   best_phase_out      phase at which peak_out occurred
module gps_acq_correlator #(
    parameter int unsigned CODE_LEN = 16368,
    parameter int unsigned STEP     = 8,
    parameter int unsigned NB_ACC   = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        ena_in,
    input  logic        start_in,
    input  logic        abort_in,
    input  logic [15:0] thr_in,
    input  logic        sample_in,
    input  logic        code_in,
    input  logic        carr_i_in,
    input  logic        carr_q_in,
    output logic        code_ena_out,
    output logic        busy_out,
    output logic        lock_out,
    output logic        fail_out,
    output logic [15:0] code_phase_out,
    output logic [15:0] peak_out,
    output logic [15:0] best_phase_out
);

    localparam int unsigned PW = 16;
    localparam int unsigned CW = $clog2(CODE_LEN + 1);
    localparam int unsigned MW = NB_ACC + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INTEG,
        S_EVAL,
        S_SLIP,
        S_LOCKED,
        S_FAIL
    } state_t;

    state_t                    state_q;
    logic signed [NB_ACC-1:0]  acc_i_q;
    logic signed [NB_ACC-1:0]  acc_q_q;
    logic [CW-1:0]             cnt_q;
    logic [PW-1:0]             phase_q;
    logic [PW-1:0]             peak_q;
    logic [PW-1:0]             best_q;
    logic [PW-1:0]             thr_q;
    logic                      busy_q;
    logic                      lock_q;
    logic                      fail_q;

    logic                      flip_i_c;
    logic                      flip_q_c;
    logic [NB_ACC-1:0]         abs_i_c;
    logic [NB_ACC-1:0]         abs_q_c;
    logic [PW-1:0]             mag_c;
    logic [PW:0]               phase_nxt_c;
    logic                      sweep_end_c;
    logic                      dwell_last_c;
    logic                      slip_last_c;

    // Correlator sign: a mismatch between sample and replica subtracts one.
    always_comb begin
        flip_i_c     = sample_in ^ code_in ^ carr_i_in;
        flip_q_c     = sample_in ^ code_in ^ carr_q_in;
        abs_i_c      = acc_i_q[NB_ACC-1] ? NB_ACC'(-acc_i_q) : NB_ACC'(acc_i_q);
        abs_q_c      = acc_q_q[NB_ACC-1] ? NB_ACC'(-acc_q_q) : NB_ACC'(acc_q_q);
        mag_c        = PW'(MW'(abs_i_c) + MW'(abs_q_c));
        phase_nxt_c  = (PW+1)'(phase_q) + (PW+1)'(STEP);
        sweep_end_c  = phase_nxt_c >= (PW+1)'(CODE_LEN);
        dwell_last_c = cnt_q == CW'(CODE_LEN - 1);
        slip_last_c  = cnt_q == CW'(STEP - 1);
    end

    // Search FSM with its datapath and the registered status flags.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            acc_i_q <= '0;
            acc_q_q <= '0;
            cnt_q   <= '0;
            phase_q <= '0;
            peak_q  <= '0;
            best_q  <= '0;
            thr_q   <= '0;
            busy_q  <= 1'b0;
            lock_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            // Flags trail the state by one cycle, except that abort clears them at once.
            busy_q <= !abort_in && (state_q == S_INTEG || state_q == S_EVAL || state_q == S_SLIP);
            lock_q <= !abort_in && (state_q == S_LOCKED);
            fail_q <= !abort_in && (state_q == S_FAIL);

            if (abort_in) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE, S_LOCKED, S_FAIL: begin
                        if (start_in) begin
                            thr_q   <= thr_in;
                            phase_q <= '0;
                            peak_q  <= '0;
                            best_q  <= '0;
                            acc_i_q <= '0;
                            acc_q_q <= '0;
                            cnt_q   <= '0;
                            state_q <= S_INTEG;
                        end
                    end
                    S_INTEG: begin
                        if (ena_in) begin
                            acc_i_q <= flip_i_c ? acc_i_q - NB_ACC'(1) : acc_i_q + NB_ACC'(1);
                            acc_q_q <= flip_q_c ? acc_q_q - NB_ACC'(1) : acc_q_q + NB_ACC'(1);
                            if (dwell_last_c) begin
                                cnt_q   <= '0;
                                state_q <= S_EVAL;
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end
                    end
                    S_EVAL: begin
                        // Strict compare keeps the earliest phase on ties.
                        if (mag_c > peak_q) begin
                            peak_q <= mag_c;
                            best_q <= phase_q;
                        end
                        if (mag_c >= thr_q) begin
                            state_q <= S_LOCKED;
                        end else if (sweep_end_c) begin
                            state_q <= S_FAIL;
                        end else begin
                            phase_q <= phase_nxt_c[PW-1:0];
                            state_q <= S_SLIP;
                        end
                    end
                    S_SLIP: begin
                        // Replica code is frozen here; the discarded samples become the delay.
                        if (ena_in) begin
                            if (slip_last_c) begin
                                cnt_q   <= '0;
                                acc_i_q <= '0;
                                acc_q_q <= '0;
                                state_q <= S_INTEG;
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign code_ena_out   = ena_in & (state_q != S_SLIP);
    assign busy_out       = busy_q;
    assign lock_out       = lock_q;
    assign fail_out       = fail_q;
    assign code_phase_out = phase_q;
    assign peak_out       = peak_q;
    assign best_phase_out = best_q;

endmodule

// File: doc/gps_acq_correlator.md
Name: gps_acq_correlator

Overview:
- Receive-side counterpart of the GPS signal generator. Performs serial code-phase acquisition on the 1-bit generated signal.
- Correlates incoming samples against a local C/A-code replica and an I/Q carrier replica, one dwell at a time. The wrapper provides the replica from gc_gen and nco instances.
- After each failed dwell it slips the replica code by a fixed number of samples. It stops when a dwell exceeds the threshold, or when the full code period has been swept.

Parameters:
- CODE_LEN, 16368, samples per C/A period (1023 chips x 16 oversampling); also the dwell length.
- STEP, 8, code-phase slip per failed dwell, in samples.
- NB_ACC, 16, signed I/Q accumulator width.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous active-high reset.
- ena_in  in  1  sample strobe, same meaning as on the generator.
- start_in  in  1  one-cycle pulse; begins a search from phase 0.
- abort_in  in  1  returns the block to IDLE.
- thr_in  in  16  detection threshold on |I|+|Q|, unsigned; sampled on start.
- sample_in  in  1  received 1-bit sample.
- code_in  in  1  local replica chip.
- carr_i_in  in  1  local carrier, in-phase.
- carr_q_in  in  1  local carrier, quadrature.
- code_ena_out  out  1  enable for the local gc_gen and its prescaler.
- busy_out  out  1  search in progress.
- lock_out  out  1  threshold crossed.
- fail_out  out  1  sweep exhausted without detection.
- code_phase_out  out  16  total applied replica delay, in samples.
- peak_out  out  16  largest |I|+|Q| seen in the current search.
- best_phase_out  out  16  phase at which peak_out occurred.

Behaviour:
- Reset (async, rst_in=1):
  - state=IDLE; accumulators, counters and all registered outputs are 0.
  - code_ena_out = ena_in, since it is combinational outside SLIP.
- States: IDLE, INTEG, EVAL, SLIP, LOCKED, FAIL.
- IDLE: on start_in:
  - latch thr_in;
  - clear phase, peak, best_phase, I/Q accumulators and the sample counter;
  - go to INTEG.
  - start_in is ignored in every other state except LOCKED and FAIL.
- INTEG, on each ena_in=1 cycle:
  - I += (sample_in ^ code_in ^ carr_i_in) ? -1 : +1;
  - Q += (sample_in ^ code_in ^ carr_q_in) ? -1 : +1;
  - count++.
  - After the CODE_LEN-th enabled sample, go to EVAL.
  - Cycles with ena_in=0 change nothing.
- EVAL (exactly one cycle, independent of ena_in):
  - mag = |I|+|Q|, 16-bit unsigned; max 2*CODE_LEN = 32736, so no overflow.
  - If mag > peak: peak=mag, best_phase=phase. Strict compare, so ties keep the earliest phase.
  - If mag >= thr: go to LOCKED.
  - Else if phase+STEP >= CODE_LEN: go to FAIL.
  - Else: phase += STEP and go to SLIP.
- SLIP:
  - code_ena_out=0; carrier is not held.
  - Count STEP enabled samples, discarding them (no accumulation).
  - Then clear accumulators and counter and go to INTEG.
- code_ena_out = ena_in & (state != SLIP).
- busy_out=1 in INTEG/EVAL/SLIP.
- LOCKED: lock_out=1; code_phase_out=phase; replica keeps running (aligned).
- FAIL: fail_out=1; code_phase_out=phase of the last dwell.
- Exit from LOCKED/FAIL: start_in restarts the search (same as from IDLE); abort_in goes to IDLE and clears lock_out/fail_out.
- abort_in in any state: next cycle state=IDLE, busy_out=0; peak/best_phase retain their values. abort_in has priority over start_in in the same cycle.
- Outputs lock_out, fail_out, busy_out, code_phase_out, peak_out and best_phase_out are registered, valid the cycle after the state transition.
- Latency, phase 0 detect: CODE_LEN enabled samples + 1 (EVAL) + 1 (output register) cycles after start_in.
- Accumulator range is ±CODE_LEN; NB_ACC=16 is sufficient. Overflow is not handled.
- Asserting rst_in mid-search returns to the reset state immediately. No partial result survives.

Test Plan:
- Zero delay: ena_in=1, sample = generator code^carr_i with the same replica, thr=12000, start_in → lock_out=1 with peak_out=16368, code_phase_out=0; lock_out rises 16370 cycles after start_in.
- Delay of 40 samples, thr=12000 → lock at code_phase_out=40 after 5 failed dwells, peak_out=16368, best_phase_out=40.
- Quadrature-only signal (sample = code^carr_q, delay 0) → |Q|=16368, lock at phase 0; I accumulation near 0.
- Unreachable thr=0xFFFF → fail_out=1 after 2046 dwells, code_phase_out=16360, best_phase_out = phase of the true peak.
- ena_in toggling 1/0, delay 16 → same result as the continuous case, in twice the cycles; code_ena_out=0 for exactly 8 enabled samples per slip.
- abort_in mid-INTEG, and rst_in mid-SLIP → state IDLE; busy_out, lock_out and fail_out all 0; code_ena_out follows ena_in; a later start_in reruns from phase 0.
